// File: rtl/mo_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mo_mul_pipe
// Purpose  : Multi-lane, fully pipelined radix-2 Montgomery multiplier
//            (MWR2MM). Computes a*b*2^-WIDTH mod Q in every lane. Each
//            iteration stage retires STAGE_BITS bits of b. One final
//            correction/output register follows the stages.
//            Data moves under valid/ready flow control with a sideband tag
//            and an occupancy counter.
// Ports    : clk, rst_n           - clock, async active-low reset
//            in_valid/in_ready    - input handshake
//            in_a, in_b           - packed operands, lane k at [k*WIDTH +: WIDTH]
//            in_tag               - sideband, returned unchanged with result
//            out_valid/out_ready  - output handshake
//            out_result, out_tag  - packed results and tag of the beat
//            inflight             - number of valid beats held in the pipe
// Config   : MO_MUL_FULL_REDUCE_EN - when defined, the final stage also
//            subtracts Q when the accumulator is >= Q.
// Revision : 1.0 - initial release
// ============================================================================
module mo_mul_pipe #(
  parameter  int WIDTH      = 13,
  parameter  int Q          = 3329,
  parameter  int STAGE_BITS = 1,
  parameter  int LANES      = 1,
  parameter  int TAG_W      = 4,
  localparam int NSTG       = (WIDTH + STAGE_BITS - 1) / STAGE_BITS,
  localparam int CNT_W      = $clog2(NSTG + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_a,
  input  logic [LANES*WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_result,
  output logic [TAG_W-1:0]       out_tag,
  output logic [CNT_W-1:0]       inflight
);

  // Signed accumulator width: holds acc + a without overflow.
  localparam int             c_AW    = WIDTH + 2;
  localparam logic [c_AW-1:0] c_Q_EXT = c_AW'(Q);

`ifdef MO_MUL_FULL_REDUCE_EN
  localparam bit c_FULL_REDUCE = 1'b1;
`else
  localparam bit c_FULL_REDUCE = 1'b0;
`endif

  if ((Q % 2) == 0 || Q >= (1 << (WIDTH - 1))) begin : g_bad_q
    $error("mo_mul_pipe: Q must be odd and below 2^(WIDTH-1)");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("mo_mul_pipe: TAG_W must be at least 1");
  end

  // One stage worth of iterations. Masks are used instead of if/else so an
  // unknown b bit or accumulator bit propagates X through this lane only.
  function automatic logic [c_AW-1:0] f_stage(
    input logic [c_AW-1:0]  acc_in,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input int               stg
  );
    logic [c_AW-1:0]  acc;
    logic [WIDTH-1:0] b_sh;
    acc = acc_in;
    for (int k = 0; k < STAGE_BITS; k++) begin
      if (stg * STAGE_BITS + k < WIDTH) begin
        b_sh = b >> (stg * STAGE_BITS + k);
        acc  = acc + ({2'b00, a} & {c_AW{b_sh[0]}});
        acc  = acc - (c_Q_EXT & {c_AW{acc[0]}});
        acc  = $signed(acc) >>> 1;
      end
    end
    return acc;
  endfunction

  // Final correction: fold a negative accumulator back into range.
  function automatic logic [WIDTH-1:0] f_final(input logic [c_AW-1:0] acc);
    logic [c_AW-1:0] v;
    v = acc + (c_Q_EXT & {c_AW{acc[c_AW-1]}});
    v = v - (c_Q_EXT & {c_AW{c_FULL_REDUCE && (v >= c_Q_EXT)}});
    return v[WIDTH-1:0];
  endfunction

  logic [NSTG-1:0]        r_vld;
  logic [c_AW-1:0]        r_acc [NSTG][LANES];
  logic [WIDTH-1:0]       r_a   [NSTG][LANES];
  logic [WIDTH-1:0]       r_b   [NSTG][LANES];
  logic [TAG_W-1:0]       r_tag [NSTG];
  logic                   r_out_valid;
  logic [LANES*WIDTH-1:0] r_out_result;
  logic [TAG_W-1:0]       r_out_tag;
  logic [CNT_W-1:0]       r_inflight;

  logic [c_AW-1:0]        w_nxt [NSTG][LANES];
  logic [LANES*WIDTH-1:0] w_final;
  logic                   w_adv;
  logic                   w_accept;
  logic                   w_out_hs;

  // Global enable: the whole pipe moves unless the output is held.
  assign w_adv    = !r_out_valid || out_ready;
  assign w_accept = in_valid && w_adv;
  assign w_out_hs = r_out_valid && out_ready;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_nxt[0][l] = f_stage('0, in_a[l*WIDTH +: WIDTH], in_b[l*WIDTH +: WIDTH], 0);
    end
    for (int s = 1; s < NSTG; s++) begin
      for (int l = 0; l < LANES; l++) begin
        w_nxt[s][l] = f_stage(r_acc[s-1][l], r_a[s-1][l], r_b[s-1][l], s);
      end
    end
  end

  always_comb begin
    w_final = '0;
    for (int l = 0; l < LANES; l++) begin
      w_final[l*WIDTH +: WIDTH] = f_final(r_acc[NSTG-1][l]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld        <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
      r_inflight   <= '0;
      for (int s = 0; s < NSTG; s++) begin
        r_tag[s] <= '0;
        for (int l = 0; l < LANES; l++) begin
          r_acc[s][l] <= '0;
          r_a[s][l]   <= '0;
          r_b[s][l]   <= '0;
        end
      end
    end else begin
      if (w_adv) begin
        r_vld[0] <= in_valid;
        r_tag[0] <= in_tag;
        for (int l = 0; l < LANES; l++) begin
          r_acc[0][l] <= w_nxt[0][l];
          r_a[0][l]   <= in_a[l*WIDTH +: WIDTH];
          r_b[0][l]   <= in_b[l*WIDTH +: WIDTH];
        end
        for (int s = 1; s < NSTG; s++) begin
          r_vld[s] <= r_vld[s-1];
          r_tag[s] <= r_tag[s-1];
          for (int l = 0; l < LANES; l++) begin
            r_acc[s][l] <= w_nxt[s][l];
            r_a[s][l]   <= r_a[s-1][l];
            r_b[s][l]   <= r_b[s-1][l];
          end
        end
        r_out_valid <= r_vld[NSTG-1];
        // Output data only changes on a real beat so it stays quiet on bubbles.
        if (r_vld[NSTG-1]) begin
          r_out_result <= w_final;
          r_out_tag    <= r_tag[NSTG-1];
        end
      end
      if (w_accept && !w_out_hs) begin
        r_inflight <= r_inflight + CNT_W'(1);
      end else if (!w_accept && w_out_hs) begin
        r_inflight <= r_inflight - CNT_W'(1);
      end
    end
  end

  assign in_ready   = w_adv;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;
  assign inflight   = r_inflight;

endmodule
`default_nettype wire

// File: tb/tb_mo_mul_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mo_mul_pipe
// Purpose  : Directed and streaming checks of mo_mul_pipe: default
//            configuration plus a 4-lane, 3-bit-per-stage instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mo_mul_pipe;

  localparam int c_Q = 3329;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [12:0] in_a, in_b, out_result;
  logic [3:0]  in_tag, out_tag, inflight;

  logic        l4_in_valid, l4_in_ready, l4_out_valid, l4_out_ready;
  logic [51:0] l4_in_a, l4_in_b, l4_out_result;
  logic [3:0]  l4_in_tag, l4_out_tag;
  logic [2:0]  l4_inflight;

  always #5 clk = ~clk;

  mo_mul_pipe u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .inflight(inflight)
  );

  mo_mul_pipe #(.LANES(4), .STAGE_BITS(3)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(l4_in_valid), .in_ready(l4_in_ready),
    .in_a(l4_in_a), .in_b(l4_in_b), .in_tag(l4_in_tag),
    .out_valid(l4_out_valid), .out_ready(l4_out_ready),
    .out_result(l4_out_result), .out_tag(l4_out_tag), .inflight(l4_inflight)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  longint rinv     = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Reference: a*b*R^-1 mod Q using a searched modular inverse of R.
  function automatic longint mont(input longint a, input longint b);
    return (((a * b) % c_Q) * rinv) % c_Q;
  endfunction

  task automatic single(input logic [12:0] a, input logic [12:0] b,
                        input logic [3:0] tag, input logic [12:0] exp, input string name);
    int lat;
    out_ready = 1'b1;
    in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    check({name, " inflight_after_accept"}, inflight, 1);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, lat, 14);
    check({name, " result"}, out_result, exp);
    check({name, " tag"}, out_tag, tag);
    @(posedge clk); #1;
    check({name, " drained"}, inflight, 0);
  endtask

  task automatic run_stream(input int n, input bit rnd, input string name);
    int          exp_r[$];
    int          exp_t[$];
    int          sent = 0, got = 0, cyc = 0;
    logic [12:0] a_v = '0, b_v = '0, hold_r;
    logic [3:0]  hold_t;
    bit          stalled, accepted;
    in_valid = 1'b0;
    while (got < n && cyc < 4000) begin
      if (sent < n && !in_valid) begin
        a_v = 13'($urandom_range(0, c_Q - 1));
        b_v = 13'($urandom_range(0, 8191));
        in_a = a_v; in_b = b_v; in_tag = 4'(sent); in_valid = 1'b1;
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      accepted = in_valid && in_ready;
      if (accepted) begin
        exp_r.push_back(int'(mont(longint'(a_v), longint'(b_v))));
        exp_t.push_back(sent % 16);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_r.size() == 0) begin
          check({name, " unexpected_beat"}, 1, 0);
        end else begin
          check({name, " result"}, out_result, exp_r.pop_front());
          check({name, " tag"}, out_tag, exp_t.pop_front());
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      hold_r  = out_result;
      hold_t  = out_tag;
      @(posedge clk); #1;
      cyc++;
      if (accepted) in_valid = 1'b0;
      if (stalled) begin
        check({name, " stall_valid"}, out_valid, 1);
        check({name, " stall_result"}, out_result, hold_r);
        check({name, " stall_tag"}, out_tag, hold_t);
      end
      check({name, " inflight_max"}, inflight <= 4'd14, 1);
    end
    in_valid = 1'b0;
    check({name, " beats"}, got, n);
    if (!rnd) check({name, " cycles"}, cyc, n + 14);
  endtask

  initial begin
    int vcount;
    for (longint r = 1; r < c_Q; r++) if (((r * 8192) % c_Q) == 1) rinv = r;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    l4_in_valid = 1'b0; l4_in_a = '0; l4_in_b = '0; l4_in_tag = '0; l4_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_result", out_result, 0);
    check("reset out_tag", out_tag, 0);
    check("reset inflight", inflight, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle in_ready", in_ready, 1);

    single(13'd1,    13'd1534, 4'h5, 13'd1,    "a1_bR");
    single(13'd1,    13'd2882, 4'hA, 13'd1534, "a1_bR2");
    single(13'd3328, 13'd1534, 4'h3, 13'd3328, "aQm1_bR");
    single(13'd0,    13'd8191, 4'hF, 13'd0,    "a0_bmax");

    run_stream(100, 1'b0, "stream");
    run_stream(100, 1'b1, "backpressure");

    // Reset with five beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 13'(100 + i); in_b = 13'(200 + i); in_tag = 4'(i); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_reset inflight", inflight, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset out_valid", out_valid, 0);
    check("async_reset out_result", out_result, 0);
    check("async_reset out_tag", out_tag, 0);
    check("async_reset inflight", inflight, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (out_valid) vcount++;
    end
    check("post_reset stale_beats", vcount, 0);
    check("post_reset inflight", inflight, 0);

    // Four lanes, three bits per stage: five iteration stages.
    l4_in_a = {13'd1234, 13'd0, 13'd3328, 13'd1};
    l4_in_b = {13'd2882, 13'd8191, 13'd1534, 13'd1534};
    l4_in_tag = 4'h9; l4_in_valid = 1'b1;
    @(posedge clk); #1;
    l4_in_valid = 1'b0;
    vcount = 1;
    while (!l4_out_valid && vcount < 20) begin
      @(posedge clk); #1;
      vcount++;
    end
    check("lanes4 latency", vcount, 6);
    check("lanes4 lane0", l4_out_result[12:0], 1);
    check("lanes4 lane1", l4_out_result[25:13], 3328);
    check("lanes4 lane2", l4_out_result[38:26], 0);
    check("lanes4 lane3", l4_out_result[51:39], 2084);
    check("lanes4 tag", l4_out_tag, 4'h9);

`ifdef MO_MUL_FULL_REDUCE_EN
    out_ready = 1'b1;
    in_a = 13'd8191; in_b = 13'd8191; in_tag = 4'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vcount = 1;
    while (!out_valid && vcount < 40) begin
      @(posedge clk); #1;
      vcount++;
    end
    check("full_reduce valid", out_valid, 1);
    check("full_reduce range", out_result < 13'd3329, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
